// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: UART receiver with mid-bit sampling and a valid/ready byte output.
// Reports framing errors and overrun. Define UART_RX_PARITY_EN to add an even-parity bit.
module uart_rx_deframer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned BITS_N       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_in,
    output logic [BITS_N-1:0] data_rx,
    output logic              valid,
    input  logic              ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    input  logic              err_clr
);

    localparam int unsigned      CYC_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned      BIT_W    = $clog2(BITS_N + 1);
    localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_N - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
    } state_t;

    logic              rx_meta, rx_s;
    state_t            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BITS_N-1:0] shift_q, shift_d;
    logic [BITS_N-1:0] data_d;
    logic              valid_d, frame_err_d, overrun_d, parity_err_d;
    logic              deliver;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_d;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        data_d       = data_rx;
        valid_d      = valid;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = overrun;
        deliver      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
`endif

        if (valid && ready) valid_d = 1'b0;
        if (err_clr)        overrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cyc_d   = '0;
                end
            end
            START: begin
                if (cyc_q == CYC_HALF) begin
                    cyc_d = '0;
                    bit_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            DATA: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    shift_d = {rx_s, shift_q[BITS_N-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
`endif
            STOP: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = ^{shift_q, par_q};
`endif
                    // A low stop bit may be a break; hold off until the line idles
                    frame_err_d = !rx_s;
                    state_d     = rx_s ? IDLE : WAIT_IDLE;
                    deliver     = rx_s && !parity_err_d;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Load only into an empty or simultaneously drained holding register
        if (deliver) begin
            if (!valid || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State, synchronizer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state_q   <= IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_rx   <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= uart_in;
            rx_s      <= rx_meta;
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_rx   <= data_d;
            valid     <= valid_d;
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q      <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_q      <= par_d;
            parity_err <= parity_err_d;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: directed frames plus randomized traffic.
// Expected events (byte or error pulse, with arrival cycle) are queued by the driver.
module tb_uart_rx_deframer;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
    localparam int NB   = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB   = 1;
`else
    localparam int PB   = 0;
`endif
    // uart_in edge -> 2 sync flops -> IDLE detect -> mid-start + NB+PB+1 bit times -> output edge
    localparam int LAT  = 4 + HALF + (NB + 1 + PB) * CPB;

    logic          clk;
    logic          rst_n;
    logic          uart_in;
    logic [NB-1:0] data_rx;
    logic          valid;
    logic          ready;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;
    logic          err_clr;

    typedef struct {
        logic          is_byte;
        logic [NB-1:0] data;
        logic          ferr;
        logic          perr;
        int unsigned   due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc_cnt = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic        vprev = 1'b0;

    uart_rx_deframer #(.CLKS_PER_BIT(CPB), .BITS_N(NB)) dut (
        .clk(clk), .rst_n(rst_n), .uart_in(uart_in), .data_rx(data_rx),
        .valid(valid), .ready(ready), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Monitor: any new byte or error pulse is matched against the queue head
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            vprev = 1'b0;
        end else begin
            if (sb.size() > 0 && cyc_cnt > sb[0].due) begin
                chk("event_missing", cyc_cnt, sb[0].due);
                void'(sb.pop_front());
            end
            if ((valid && !vprev) || frame_err || parity_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'({valid && !vprev, frame_err, parity_err}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("evt_time", cyc_cnt, e.due);
                    chk("evt_kind", 32'({valid && !vprev, frame_err, parity_err}),
                        32'({e.is_byte, e.ferr, e.perr}));
                    if (e.is_byte) chk("evt_data", 32'(data_rx), 32'(e.data));
                end
            end
            vprev = valid;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        uart_in = b;
        idle(CPB);
    endtask

    // One frame; a bad stop bit is held low for two bit times, then the line idles
    task automatic send_frame(input logic [NB-1:0] d, input bit stop_ok, input bit par_ok,
                              input bit push);
        exp_t e;
        logic p;
        @(posedge clk);
        #1;
        e.is_byte = stop_ok && par_ok;
        e.data    = d;
        e.ferr    = !stop_ok;
        e.perr    = !par_ok;
        e.due     = cyc_cnt + LAT;
        if (push) sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < NB; i++) drive_bit(d[i]);
        if (PB != 0) begin
            p = ^d;
            drive_bit(par_ok ? p : ~p);
        end
        if (stop_ok) begin
            drive_bit(1'b1);
        end else begin
            drive_bit(1'b0);
            drive_bit(1'b0);
            drive_bit(1'b1);
        end
    endtask

    task automatic glitch(input int len);
        @(posedge clk);
        #1;
        uart_in = 1'b0;
        idle(len);
        uart_in = 1'b1;
        idle(2 * CPB);
    endtask

    initial begin
        rst_n   = 1'b0;
        uart_in = 1'b1;
        ready   = 1'b1;
        err_clr = 1'b0;
        idle(3);
        chk("rst_data", 32'(data_rx), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        idle(2 * CPB);

        send_frame(8'h7B, 1'b1, 1'b1, 1'b1);
        chk("single_pulse", 32'(valid), 32'd0);

        glitch(4);
        chk("glitch_valid", 32'(valid), 32'd0);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        chk("break_valid", 32'(valid), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);

        // Consumer stalled: second byte is dropped and overrun sticks
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1, 1'b1);
        chk("ovr_before", 32'(overrun), 32'd0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        chk("hold_valid", 32'(valid), 32'd1);
        chk("hold_data", 32'(data_rx), 32'h11);
        chk("ovr_set", 32'(overrun), 32'd1);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        chk("consume_valid", 32'(valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
        ready = 1'b1;
        idle(CPB);

        // Reset in the middle of a data bit of 0x55
        @(posedge clk);
        #1;
        uart_in = 1'b0;
        idle(CPB);
        uart_in = 1'b1;
        idle(CPB);
        uart_in = 1'b0;
        idle(CPB / 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_data", 32'(data_rx), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_ferr", 32'(frame_err), 32'd0);
        chk("midrst_ovr", 32'(overrun), 32'd0);
        uart_in = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(2 * CPB);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
`endif

        // Randomized traffic: gaps, short glitches, occasional bad stop/parity bits
        for (int k = 0; k < 24; k++) begin
            logic [NB-1:0] d;
            bit            s_ok;
            bit            p_ok;
            d    = NB'($urandom);
            s_ok = ($urandom_range(0, 7) != 0);
            p_ok = (PB == 0) || ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) glitch(int'($urandom_range(1, 6)));
            idle(int'($urandom_range(0, 20)));
            send_frame(d, s_ok, p_ok, 1'b1);
        end

        idle(2 * CPB);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- UART receiver: the receive-side counterpart of the motor-link UART transmitter.
- Takes the serial line from the motor controller on a GPIO pin and recovers 8N1 frames by mid-bit sampling.
- Presents each byte on a valid/ready handshake for the downstream command/feedback parser.
- Flags framing errors and overrun.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50_000_000/115_200); must be >= 4.
- BITS_N, 8, data bits per frame, LSB first.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- rst_n  input  1  asynchronous active-low reset.
- uart_in  input  1  raw serial line; idle high; asynchronous to clk.
- data_rx  output  BITS_N  received byte; stable while valid=1.
- valid  output  1  byte available.
- ready  input  1  consumer accepts when valid&ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 without macro).
- overrun  output  1  sticky: a completed byte was dropped.
- err_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset:
  - Async assert of rst_n clears everything: data_rx=0, valid=0, frame_err=0, parity_err=0, overrun=0.
  - Synchronizer flops preset to 1; state=IDLE; bit counter and cycle counter =0.
  - Deassertion takes effect on the next clk edge.
- Input sync: uart_in passes through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
- States: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
- IDLE: rx_s==0 -> START, cyc=0.
- START: sample when cyc==(CLKS_PER_BIT-1)/2.
  - rx_s==1: false start -> IDLE, no outputs.
  - rx_s==0: cyc=0 -> DATA, bit=0.
- DATA:
  - Sample when cyc==CLKS_PER_BIT-1; shift[bit]=rx_s; cyc=0; bit++.
  - After bit==BITS_N-1 -> STOP (or PARITY under macro).
- STOP: sample when cyc==CLKS_PER_BIT-1.
  - rx_s==1: deliver the byte -> IDLE.
  - rx_s==0: frame_err=1 for exactly one cycle, byte discarded -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then -> IDLE. Prevents a break condition from being read as 0x00 frames.
- Delivery (the cycle after the stop sample):
  - valid==0: data_rx<=shift, valid<=1.
  - valid==1 && ready==1 in the same cycle: the old byte is consumed and the new byte is loaded; valid stays 1, no overrun.
  - valid==1 && ready==0: new byte dropped, data_rx unchanged, overrun<=1.
- Handshake: valid deasserts the cycle after valid&ready when no new delivery coincides. data_rx must not change while valid=1 and ready=0.
- overrun: sticky until err_clr=1 or reset. If err_clr and a new overrun event occur in the same cycle, overrun=1 (set wins).
- Latency: valid rises exactly 1 cycle after the stop-bit sample edge. Stop sample is at (CLKS_PER_BIT-1)/2 + (BITS_N+1)*CLKS_PER_BIT cycles after rx_s falls (plus one CLKS_PER_BIT under the macro).
- Back-to-back frames: a start edge is accepted in IDLE on the cycle after delivery. No inter-frame gap beyond the stop bit is required.
- Reset mid-frame: the partial frame is lost and no error is flagged. The receiver resynchronizes on the next falling edge after the line is high.
- Counters: cyc has width $clog2(CLKS_PER_BIT); bit has width $clog2(BITS_N+1). No wrap beyond the compare values.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP; one bit sampled at cyc==CLKS_PER_BIT-1.
  - Even parity: XOR of data bits and the parity bit must be 0.
  - Mismatch: parity_err pulses one cycle at the stop-sample cycle, byte discarded, no valid. Stop-bit checking still applies.
  - If both errors occur, both pulse in the same cycle and the FSM goes to WAIT_IDLE.
- Not defined: 8N1 only; parity_err tied 0; no PARITY state.

Test Plan:
- CLKS_PER_BIT=16, ready=1, drive frame 0x7B -> single valid pulse, data_rx=8'h7B, frame_err=0, valid asserted 1 cycle after the stop sample.
- Low glitch of 4 cycles on idle line -> FSM returns to IDLE from START, valid never asserts, no errors.
- Frame 0xA5 with stop bit driven 0 for 2 bit times, then high -> frame_err pulses once, valid=0, no 0x00 byte; next frame 0x3C received correctly.
- ready=0, send 0x11 then 0x22 back-to-back -> data_rx holds 8'h11, valid=1, overrun=1. Raise ready for 1 cycle -> valid=0. err_clr -> overrun=0.
- Assert rst_n=0 mid DATA of 0x55, release, send 0xC3 -> all outputs 0 during reset, then data_rx=8'hC3, no errors.
- With UART_RX_PARITY_EN: 0x07 with parity 1 -> accepted. 0x07 with parity 0 -> parity_err pulse, no valid.
